// File: rtl/prbs_ber_monitor.sv
// Multi-lane self-synchronising PRBS bit-error-rate monitor.
// Each lane seeds from the received stream, confirms lock, counts errors and re-acquires on loss.
module prbs_ber_monitor #(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned PRBS_ORDER = 9,
  parameter int unsigned NBT_CNT    = 64,
  parameter int unsigned NBT_LOSS   = 16,
  parameter int unsigned LOCK_BITS  = 32,
  parameter int unsigned LOSS_WIN   = 64,
  parameter int unsigned LOSS_ERR   = 8
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_clear,
  input  logic [NUM_LANES-1:0]          i_valid,
  input  logic [NUM_LANES-1:0]          i_bit,
  output logic [NUM_LANES-1:0]          o_lock,
  output logic [NUM_LANES*NBT_CNT-1:0]  o_err_cnt,
  output logic [NUM_LANES*NBT_CNT-1:0]  o_tot_cnt,
  output logic [NUM_LANES*NBT_LOSS-1:0] o_loss_cnt
);

  localparam int unsigned TAP2 = (PRBS_ORDER == 7)  ? 6  :
                                 (PRBS_ORDER == 9)  ? 5  :
                                 (PRBS_ORDER == 15) ? 14 :
                                 (PRBS_ORDER == 23) ? 18 :
                                 (PRBS_ORDER == 31) ? 28 : 0;
  localparam int unsigned TAP_IDX = (TAP2 == 0) ? 0 : TAP2 - 1;
  localparam int unsigned CNT_MAX = (PRBS_ORDER > LOCK_BITS) ? PRBS_ORDER : LOCK_BITS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned WW      = $clog2(LOSS_WIN + 1);

  if (TAP2 == 0 || LOCK_BITS < 1 || LOSS_ERR < 1 || LOSS_ERR > LOSS_WIN) begin : g_bad_param
    $error("prbs_ber_monitor: unsupported parameter set");
  end

  typedef enum logic [1:0] {StSeed, StCheck, StLocked} state_e;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    state_e                state_q, state_d;
    logic [PRBS_ORDER-1:0] sr_q, sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WW-1:0]         wbits_q, wbits_d, werr_q, werr_d;
    logic [WW-1:0]         wbits_inc, werr_inc;
    logic [NBT_CNT-1:0]    err_q, err_d, tot_q, tot_d;
    logic [NBT_LOSS-1:0]   loss_q, loss_d;
    logic                  acc, exp_bit, mis;

    assign acc       = i_enable & i_valid[n];
    assign exp_bit   = sr_q[PRBS_ORDER-1] ^ sr_q[TAP_IDX];
    assign mis       = i_bit[n] ^ exp_bit;
    assign wbits_inc = wbits_q + WW'(1);
    assign werr_inc  = werr_q + WW'(mis);

    always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      wbits_d = wbits_q;
      werr_d  = werr_q;
      err_d   = err_q;
      tot_d   = tot_q;
      loss_d  = loss_q;
      if (acc) begin
        unique case (state_q)
          StSeed: begin
            sr_d = {sr_q[PRBS_ORDER-2:0], i_bit[n]};
            if (cnt_q == CW'(PRBS_ORDER - 1)) begin
              state_d = StCheck;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          StCheck: begin
            sr_d = {sr_q[PRBS_ORDER-2:0], exp_bit};
            if (mis) begin
              state_d = StSeed;
              cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_BITS - 1)) begin
              state_d = StLocked;
              cnt_d   = '0;
              wbits_d = '0;
              werr_d  = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          StLocked: begin
            // Reference free-runs so a received error never corrupts it.
            sr_d = {sr_q[PRBS_ORDER-2:0], exp_bit};
            if (!(&tot_q))       tot_d = tot_q + NBT_CNT'(1);
            if (mis && !(&err_q)) err_d = err_q + NBT_CNT'(1);
            if (werr_inc == WW'(LOSS_ERR)) begin
              state_d = StSeed;
              cnt_d   = '0;
              if (!(&loss_q)) loss_d = loss_q + NBT_LOSS'(1);
            end else if (wbits_inc == WW'(LOSS_WIN)) begin
              wbits_d = '0;
              werr_d  = '0;
            end else begin
              wbits_d = wbits_inc;
              werr_d  = werr_inc;
            end
          end
          default: state_d = StSeed;
        endcase
      end
      if (i_clear) begin
        err_d  = '0;
        tot_d  = '0;
        loss_d = '0;
      end
    end

    always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
        state_q <= StSeed;
        sr_q    <= '0;
        cnt_q   <= '0;
        wbits_q <= '0;
        werr_q  <= '0;
        err_q   <= '0;
        tot_q   <= '0;
        loss_q  <= '0;
      end else begin
        state_q <= state_d;
        sr_q    <= sr_d;
        cnt_q   <= cnt_d;
        wbits_q <= wbits_d;
        werr_q  <= werr_d;
        err_q   <= err_d;
        tot_q   <= tot_d;
        loss_q  <= loss_d;
      end
    end

    assign o_lock[n]                          = (state_q == StLocked);
    assign o_err_cnt[n*NBT_CNT +: NBT_CNT]    = err_q;
    assign o_tot_cnt[n*NBT_CNT +: NBT_CNT]    = tot_q;
    assign o_loss_cnt[n*NBT_LOSS +: NBT_LOSS] = loss_q;
  end

endmodule

// File: tb/tb_prbs_ber_monitor.sv
// Bench for prbs_ber_monitor: directed vector table, saturation instance, and randomized
// two-lane run against a sequence-level reference model.
module tb_prbs_ber_monitor;

  logic         clk = 1'b0;
  logic         rst_n, en, clr;
  logic [1:0]   valid, bitv;
  logic [1:0]   o_lock;
  logic [127:0] o_err_cnt, o_tot_cnt;
  logic [31:0]  o_loss_cnt;

  logic         s_valid, s_bit, s_clr, s_lock;
  logic [3:0]   s_err, s_tot;
  logic [15:0]  s_loss;

  always #5 clk = ~clk;

  prbs_ber_monitor dut (
    .clk(clk), .i_reset(rst_n), .i_enable(en), .i_clear(clr), .i_valid(valid), .i_bit(bitv),
    .o_lock(o_lock), .o_err_cnt(o_err_cnt), .o_tot_cnt(o_tot_cnt), .o_loss_cnt(o_loss_cnt)
  );

  prbs_ber_monitor #(.NUM_LANES(1), .NBT_CNT(4), .LOSS_WIN(64), .LOSS_ERR(64)) dut_sat (
    .clk(clk), .i_reset(rst_n), .i_enable(en), .i_clear(s_clr), .i_valid(s_valid), .i_bit(s_bit),
    .o_lock(s_lock), .o_err_cnt(s_err), .o_tot_cnt(s_tot), .o_loss_cnt(s_loss)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Stimulus source: PRBS9 (x9+x5+1) generator.
  task automatic prbs_next(input logic [8:0] gi, output logic [8:0] go, output logic b);
    b  = gi[8] ^ gi[4];
    go = {gi[7:0], b};
  endtask

  logic [8:0] g0, g1, gs;

  // Lane 0 receives one bit every 4th cycle.
  task automatic feed0(input int n, input bit inv, input bit c);
    logic b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prbs_next(g0, g0, b);
      bitv[0] = b ^ inv;
      valid   = 2'b01;
      clr     = c && (i == 0);
      @(negedge clk);
      valid = 2'b00;
      clr   = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic feed_s(input int n, input bit inv);
    logic b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prbs_next(gs, gs, b);
      s_bit   = b ^ inv;
      s_valid = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Reference model: reference sequence kept as a bit history; expected bit is x[k-9]^x[k-5].
  localparam int HMAX = 16384;
  bit              href  [2][HMAX];
  int              mn    [2];
  int              mmode [2];  // 0 seeding, 1 confirming, 2 locked
  int              mcnt  [2];
  int              mwb   [2];
  int              mwe   [2];
  longint unsigned merr  [2];
  longint unsigned mtot  [2];
  int              mloss [2];

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 9; k++) href[l][k] = 1'b0;
      mn[l] = 9; mmode[l] = 0; mcnt[l] = 0; mwb[l] = 0; mwe[l] = 0;
      merr[l] = 0; mtot[l] = 0; mloss[l] = 0;
    end
  endtask

  task automatic model_step(input int l, input bit b, input bit acc, input bit c);
    bit e;
    if (acc) begin
      e = href[l][mn[l]-9] ^ href[l][mn[l]-5];
      href[l][mn[l]] = (mmode[l] == 0) ? b : e;
      mn[l]++;
      if (mmode[l] == 0) begin
        mcnt[l]++;
        if (mcnt[l] == 9) begin mmode[l] = 1; mcnt[l] = 0; end
      end else if (mmode[l] == 1) begin
        if (b != e) begin mmode[l] = 0; mcnt[l] = 0; end
        else begin
          mcnt[l]++;
          if (mcnt[l] == 32) begin mmode[l] = 2; mwb[l] = 0; mwe[l] = 0; end
        end
      end else begin
        mtot[l]++;
        if (b != e) begin merr[l]++; mwe[l]++; end
        mwb[l]++;
        if (mwe[l] == 8) begin
          mmode[l] = 0; mcnt[l] = 0;
          if (mloss[l] < 65535) mloss[l]++;
        end else if (mwb[l] == 64) begin
          mwb[l] = 0; mwe[l] = 0;
        end
      end
    end
    if (c) begin merr[l] = 0; mtot[l] = 0; mloss[l] = 0; end
  endtask

  task automatic check_zero(input string name);
    check(name, longint'({|o_lock, |o_err_cnt, |o_tot_cnt, |o_loss_cnt}), 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid = 2'b00;
    clr   = 1'b0;
    #1;
    check_zero("async_reset_zero");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    string           name;
    int              n;
    bit              inv;
    bit              clr;
    bit              lock;
    longint unsigned err;
    longint unsigned tot;
    int              loss;
  } rec_t;

  rec_t tbl [12];

  initial begin
    int rate;
    logic b;
    tbl[0]  = '{"pre_lock",      40,   0, 0, 0, 0, 0,    0};
    tbl[1]  = '{"lock_41",       1,    0, 0, 1, 0, 0,    0};
    tbl[2]  = '{"clean10",       10,   0, 0, 1, 0, 10,   0};
    tbl[3]  = '{"single_err",    1,    1, 0, 1, 1, 11,   0};
    tbl[4]  = '{"clean1000",     1000, 0, 0, 1, 1, 1011, 0};
    tbl[5]  = '{"seven_err",     7,    1, 0, 1, 8, 1018, 0};
    tbl[6]  = '{"loss",          1,    1, 0, 0, 9, 1019, 1};
    tbl[7]  = '{"relock_40",     40,   0, 0, 0, 9, 1019, 1};
    tbl[8]  = '{"relock_41",     1,    0, 0, 1, 9, 1019, 1};
    tbl[9]  = '{"post_relock",   5,    0, 0, 1, 9, 1024, 1};
    tbl[10] = '{"clear_collide", 1,    1, 1, 1, 0, 0,    0};
    tbl[11] = '{"after_clear",   1,    0, 0, 1, 0, 1,    0};

    rst_n = 1'b0; en = 1'b1; clr = 1'b0; valid = 2'b00; bitv = 2'b00;
    s_valid = 1'b0; s_bit = 1'b0; s_clr = 1'b0;
    g0 = 9'h1AA; gs = 9'h0B3;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      feed0(tbl[i].n, tbl[i].inv, tbl[i].clr);
      check({tbl[i].name, "_lock"}, longint'(o_lock[0]), longint'(tbl[i].lock));
      check({tbl[i].name, "_err"},  o_err_cnt[63:0], tbl[i].err);
      check({tbl[i].name, "_tot"},  o_tot_cnt[63:0], tbl[i].tot);
      check({tbl[i].name, "_loss"}, longint'(o_loss_cnt[15:0]), longint'(tbl[i].loss));
    end
    check("lane1_idle", longint'({o_lock[1], |o_err_cnt[127:64], |o_tot_cnt[127:64],
                                  |o_loss_cnt[31:16]}), 0);

    // Narrow counters must stick at all-ones under a continuous error stream.
    feed_s(41, 0);
    check("sat_lock", longint'(s_lock), 1);
    feed_s(14, 1);
    check("sat_err14", longint'(s_err), 14);
    check("sat_tot14", longint'(s_tot), 14);
    feed_s(6, 1);
    check("sat_err_hold", longint'(s_err), 15);
    check("sat_tot_hold", longint'(s_tot), 15);
    check("sat_still_lock", longint'({s_lock, s_loss}), longint'(17'h10000));

    // Randomized two-lane run, starting with a reset while lane 0 is locked.
    async_reset();
    g0 = 9'($urandom_range(511, 1));
    g1 = 9'h1FE;
    rate = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        check($sformatf("rand_l%0d_lock", l), longint'(o_lock[l]), longint'(mmode[l] == 2));
        check($sformatf("rand_l%0d_err", l), o_err_cnt[l*64 +: 64], merr[l]);
        check($sformatf("rand_l%0d_tot", l), o_tot_cnt[l*64 +: 64], mtot[l]);
        check($sformatf("rand_l%0d_loss", l), longint'(o_loss_cnt[l*16 +: 16]),
              longint'(mloss[l]));
      end
      if (cyc == 3000) begin
        async_reset();
      end else begin
        if (cyc % 256 == 0) rate = $urandom_range(2);
        en  = ($urandom_range(31) != 0);
        clr = ($urandom_range(127) == 0);
        for (int l = 0; l < 2; l++) begin
          valid[l] = 1'($urandom_range(1));
          if (valid[l] && en) begin
            if (l == 0) prbs_next(g0, g0, b);
            else        prbs_next(g1, g1, b);
            if ((rate == 1 && $urandom_range(63) == 0) || (rate == 2 && $urandom_range(2) == 0))
              b = ~b;
            bitv[l] = b;
          end else begin
            bitv[l] = 1'($urandom_range(1));
          end
          model_step(l, bitv[l], valid[l] && en, clr);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
